// File: rtl/corr_pkg.sv
// Shared types and helpers for the sign-correlation window dump block.
// Baseline ordering: (0,1),(0,2)..(0,N-1),(1,2)..
package corr_pkg;

    localparam int DROP_W = 16;

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic int nb(input int nch);
        return nch * (nch - 1) / 2;
    endfunction

    function automatic int pair_idx(input int i, input int j, input int nch);
        int base;
        base = 0;
        for (int k = 0; k < i; k++) begin
            base += nch - 1 - k;
        end
        return base + (j - i - 1);
    endfunction

endpackage

// File: rtl/corr_pair_acc.sv
// Single correlation accumulator with clear; wraps by default, or saturates
// when CORR_SATURATE_EN is defined.
module corr_pair_acc #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [ACC_W-1:0] count,
    output logic [ACC_W-1:0] count_next
);

    // count_next already includes this cycle's increment, so a window
    // closing on this edge can capture it before the clear lands.
    always_comb begin
`ifdef CORR_SATURATE_EN
        count_next = (inc && (count != '1)) ? count + ACC_W'(1) : count;
`else
        count_next = inc ? count + ACC_W'(1) : count;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/corr_window_dump.sv
// Windowed 1-bit correlator: accumulates XNOR products per baseline, snapshots
// on window_end rising edge and streams the window out. Option: CORR_SATURATE_EN.
module corr_window_dump
    import corr_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int ACC_W = 32,
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    sample_in,
    input  logic              sample_valid,
    input  logic              window_end,
    output logic [ACC_W-1:0]  m_data,
    output logic [IDX_W-1:0]  m_index,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overrun,
    output logic [DROP_W-1:0] drop_count
);

    localparam int NB = nb(NCH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB);

    logic [ACC_W-1:0] acc_cnt [NB];
    logic [ACC_W-1:0] acc_nxt [NB];
    logic [ACC_W-1:0] shadow_acc [NB];
    logic [ACC_W-1:0] scnt, scnt_nxt, shadow_scnt;

    logic window_end_q, tick, streaming, accept, start, drop;
    state_t state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;

    assign tick      = window_end & ~window_end_q;
    assign streaming = (state_q == STREAM);
    assign accept    = streaming & m_ready;
    // A stream finishing on the tick edge frees the shadow bank, so no drop.
    assign start     = tick & (~streaming | (accept & (index_q == LAST_IDX)));
    assign drop      = tick & ~start;

    for (genvar i = 0; i < NCH; i++) begin : g_row
        for (genvar j = i + 1; j < NCH; j++) begin : g_col
            localparam int K = pair_idx(i, j, NCH);
            logic inc;
            assign inc = sample_valid & (sample_in[i] ~^ sample_in[j]);
            corr_pair_acc #(.ACC_W(ACC_W)) u_acc (
                .clk        (clk),
                .reset      (reset),
                .inc        (inc),
                .clr        (tick),
                .count      (acc_cnt[K]),
                .count_next (acc_nxt[K])
            );
        end
    end

    corr_pair_acc #(.ACC_W(ACC_W)) u_scnt (
        .clk        (clk),
        .reset      (reset),
        .inc        (sample_valid),
        .clr        (tick),
        .count      (scnt),
        .count_next (scnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_scnt <= '0;
            for (int k = 0; k < NB; k++) shadow_acc[k] <= '0;
        end else if (start) begin
            shadow_scnt <= scnt_nxt;
            for (int k = 0; k < NB; k++) shadow_acc[k] <= acc_nxt[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            index_q      <= '0;
            window_end_q <= 1'b0;
            overrun      <= 1'b0;
            drop_count   <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            window_end_q <= window_end;
            if (drop) begin
                overrun <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        m_valid = streaming;
        m_index = index_q;
        m_last  = streaming && (index_q == LAST_IDX);
        m_data  = '0;
        if (accept) begin
            if (index_q == LAST_IDX) begin
                state_d = IDLE;
                index_d = '0;
            end else begin
                index_d = index_q + IDX_W'(1);
            end
        end
        if (start) begin
            state_d = STREAM;
            index_d = '0;
        end
        if (streaming) begin
            if (index_q == '0) m_data = shadow_scnt;
            for (int k = 0; k < NB; k++) begin
                if (index_q == IDX_W'(k + 1)) m_data = shadow_acc[k];
            end
        end
    end

endmodule

// File: tb/tb_corr_window_dump.sv
// Scoreboard bench for corr_window_dump: directed windows push expected words,
// monitors pop and compare on every accepted output word.
module tb_corr_window_dump;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  index;
        logic        last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  sample_in;
    logic        sample_valid;
    logic        window_end;
    logic [31:0] m_data;
    logic [3:0]  m_index;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        overrun;
    logic [15:0] drop_count;

    logic [3:0]  sample_in8;
    logic        sample_valid8;
    logic        window_end8;
    logic [7:0]  m_data8;
    logic [3:0]  m_index8;
    logic        m_last8;
    logic        m_valid8;
    logic        m_ready8;
    logic        overrun8;
    logic [15:0] drop_count8;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t q8[$];

    logic        stall_pend = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_index;
    logic        held_last;

    corr_window_dump #(.NCH(4), .ACC_W(32), .IDX_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .window_end   (window_end),
        .m_data       (m_data),
        .m_index      (m_index),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .overrun      (overrun),
        .drop_count   (drop_count)
    );

    corr_window_dump #(.NCH(4), .ACC_W(8), .IDX_W(4)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in8),
        .sample_valid (sample_valid8),
        .window_end   (window_end8),
        .m_data       (m_data8),
        .m_index      (m_index8),
        .m_last       (m_last8),
        .m_valid      (m_valid8),
        .m_ready      (m_ready8),
        .overrun      (overrun8),
        .drop_count   (drop_count8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_window(input int s, input int a01, input int a02, input int a03,
                               input int a12, input int a13, input int a23);
        int w[7];
        w = '{s, a01, a02, a03, a12, a13, a23};
        for (int k = 0; k < 7; k++) begin
            q.push_back('{data: 32'(w[k]), index: 4'(k), last: (k == 6)});
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pattern, input int n);
        sample_in    = pattern;
        sample_valid = 1'b1;
        repeat (n) step();
        sample_valid = 1'b0;
    endtask

    task automatic pulse(input bit expect_start);
        window_end = 1'b1;
        step();
        window_end = 1'b0;
        if (expect_start) begin
            checkOutput("start_valid", 32'(m_valid), 32'd1);
            checkOutput("start_index", 32'(m_index), 32'd0);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((q.size() != 0 || m_valid) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: timed out with %0d words pending", q.size());
        end
        checkOutput("queue_drained", 32'(q.size()), 32'd0);
    endtask

    // Main monitor: compares every accepted word and checks stall stability.
    always @(negedge clk) begin
        if (reset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                checkOutput("stall_valid", 32'(m_valid), 32'd1);
                checkOutput("stall_data", m_data, held_data);
                checkOutput("stall_index", 32'(m_index), 32'(held_index));
                checkOutput("stall_last", 32'(m_last), 32'(held_last));
            end
            if (m_valid && m_ready) begin
                stall_pend = 1'b0;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: index %0d data %0h, expected none",
                             m_index, m_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checkOutput($sformatf("data_idx%0d", e.index), m_data, e.data);
                    checkOutput("word_index", 32'(m_index), 32'(e.index));
                    checkOutput("word_last", 32'(m_last), 32'(e.last));
                end
            end else if (m_valid) begin
                stall_pend = 1'b1;
                held_data  = m_data;
                held_index = m_index;
                held_last  = m_last;
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    // Narrow-instance monitor for the wrap/saturate window.
    always @(negedge clk) begin
        if (!reset && m_valid8 && m_ready8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word8: index %0d data %0h, expected none",
                         m_index8, m_data8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                checkOutput($sformatf("data8_idx%0d", e.index), {24'd0, m_data8}, e.data);
                checkOutput("word8_index", 32'(m_index8), 32'(e.index));
                checkOutput("word8_last", 32'(m_last8), 32'(e.last));
            end
        end
    end

    initial begin
        int n;
        logic [31:0] exp8;

        reset         = 1'b1;
        sample_in     = 4'd0;
        sample_valid  = 1'b0;
        window_end    = 1'b0;
        m_ready       = 1'b0;
        sample_in8    = 4'd0;
        sample_valid8 = 1'b0;
        window_end8   = 1'b0;
        m_ready8      = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        $display("[TB] reset state");
        checkOutput("rst_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_index", 32'(m_index), 32'd0);
        checkOutput("rst_last", 32'(m_last), 32'd0);
        checkOutput("rst_data", m_data, 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_drop_count", 32'(drop_count), 32'd0);

        $display("[TB] test 1: 100 samples of 0011");
        m_ready = 1'b1;
        applyStimulus(4'b0011, 100);
        push_window(100, 100, 0, 0, 0, 0, 100);
        pulse(1'b1);
        wait_idle(50);
        checkOutput("t1_overrun", 32'(overrun), 32'd0);

        $display("[TB] test 2: window_end held high");
        applyStimulus(4'b0101, 20);
        push_window(20, 0, 20, 0, 0, 20, 0);
        push_window(9, 9, 9, 9, 9, 9, 9);
        window_end = 1'b1;
        step();
        checkOutput("t2_start_valid", 32'(m_valid), 32'd1);
        applyStimulus(4'b1111, 9);
        window_end = 1'b0;
        step();
        pulse(1'b1);
        wait_idle(50);
        checkOutput("t2_overrun", 32'(overrun), 32'd0);
        checkOutput("t2_drop_count", 32'(drop_count), 32'd0);

        $display("[TB] test 3: stall and dropped window");
        m_ready = 1'b0;
        applyStimulus(4'b0011, 10);
        push_window(10, 10, 0, 0, 0, 0, 10);
        pulse(1'b1);
        repeat (20) step();
        applyStimulus(4'b1111, 3);
        pulse(1'b0);
        checkOutput("t3_overrun", 32'(overrun), 32'd1);
        checkOutput("t3_drop_count", 32'(drop_count), 32'd1);
        checkOutput("t3_still_valid", 32'(m_valid), 32'd1);
        checkOutput("t3_still_index", 32'(m_index), 32'd0);
        m_ready = 1'b1;
        wait_idle(50);
        push_window(0, 0, 0, 0, 0, 0, 0);
        pulse(1'b1);
        wait_idle(50);

        $display("[TB] test 4: sample valid in tick cycle");
        applyStimulus(4'b0011, 4);
        push_window(5, 5, 0, 0, 0, 0, 5);
        sample_in    = 4'b0011;
        sample_valid = 1'b1;
        window_end   = 1'b1;
        step();
        sample_valid = 1'b0;
        window_end   = 1'b0;
        wait_idle(50);
        applyStimulus(4'b1111, 2);
        push_window(2, 2, 2, 2, 2, 2, 2);
        pulse(1'b1);
        wait_idle(50);

        $display("[TB] test 5: reset mid-stream");
        applyStimulus(4'b1111, 7);
        for (int k = 0; k < 3; k++) begin
            q.push_back('{data: 32'd7, index: 4'(k), last: 1'b0});
        end
        pulse(1'b1);
        sample_in    = 4'b0101;
        sample_valid = 1'b1;
        n = 0;
        while (m_index != 4'd3 && n < 10) begin
            step();
            n++;
        end
        checkOutput("t5_reached_idx3", 32'(m_index), 32'd3);
        m_ready      = 1'b0;
        sample_valid = 1'b0;
        reset        = 1'b1;
        step();
        checkOutput("t5_valid", 32'(m_valid), 32'd0);
        checkOutput("t5_index", 32'(m_index), 32'd0);
        checkOutput("t5_data", m_data, 32'd0);
        checkOutput("t5_overrun", 32'(overrun), 32'd0);
        checkOutput("t5_drop_count", 32'(drop_count), 32'd0);
        checkOutput("t5_queue", 32'(q.size()), 32'd0);
        reset   = 1'b0;
        m_ready = 1'b1;
        step();
        push_window(0, 0, 0, 0, 0, 0, 0);
        pulse(1'b1);
        wait_idle(50);

        $display("[TB] test 6: 300 samples into 8-bit accumulators");
`ifdef CORR_SATURATE_EN
        exp8 = 32'd255;
`else
        exp8 = 32'd44;
`endif
        sample_in8    = 4'b1111;
        sample_valid8 = 1'b1;
        repeat (300) step();
        sample_valid8 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            q8.push_back('{data: exp8, index: 4'(k), last: (k == 6)});
        end
        window_end8 = 1'b1;
        step();
        window_end8 = 1'b0;
        n = 0;
        while ((q8.size() != 0 || m_valid8) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle8: timed out with %0d words pending", q8.size());
        end
        checkOutput("queue8_drained", 32'(q8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
